// File: rtl/ppe_pkg.sv
// ppe_pkg: shared definitions for the PPE request tracker.
//   N       number of queues / request bits
//   IDX_W   queue index width (clog2(N))
//   CNT_W   per-queue occupancy counter width
//   CNT_MAX largest occupancy a queue can hold
//   qid_t   queue index type
//   cnt_t   occupancy counter type
package ppe_pkg;

  localparam int N     = 512;
  localparam int IDX_W = 9;
  localparam int CNT_W = 4;

  typedef logic [IDX_W-1:0] qid_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/ppe_req_qcnt.sv
// ppe_req_qcnt: one per-queue occupancy counter cell.
// The parent only raises inc when the queue has room (or a same-cycle dec
// frees a slot) and only raises dec when the queue is non-empty, so the
// cell never wraps.
// Ports:
//   clk    clock
//   rst    synchronous active-high reset
//   inc    accepted enqueue for this queue
//   dec    accepted dequeue for this queue
//   full   counter at its maximum (pre-edge value)
//   empty  counter at zero (pre-edge value)
//   req    registered request bit, equal to (cnt != 0) after the update
module ppe_req_qcnt
  import ppe_pkg::*;
#(
  parameter int CNT_W = ppe_pkg::CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty,
  output logic req
);

  logic [CNT_W-1:0] cnt;

  assign full  = (cnt == '1);
  assign empty = (cnt == '0);

  // NOTE: state registers use non-blocking assignments so every cell and the
  // top-level accounting all update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      req <= 1'b0;
    end else begin
      unique case ({inc, dec})
        2'b10: begin
          cnt <= cnt + 1'b1;
          req <= 1'b1;
        end
        2'b01: begin
          cnt <= cnt - 1'b1;
          // Request drops only when the last entry leaves.
          req <= (cnt != CNT_W'(1));
        end
        default: ; // idle, or inc+dec cancelling out
      endcase
    end
  end

endmodule

// File: rtl/ppe_req_tracker.sv
// ppe_req_tracker: per-queue occupancy tracker producing the registered
// request vector for the programmable priority encoder.
// Optional statistics counters are built when PPE_REQ_STATS_EN is defined;
// otherwise the stat_* ports are tied to zero.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   enq_valid  enqueue event this cycle
//   enq_qid    target queue of the enqueue
//   deq_valid  dequeue event (PPE grant valid)
//   deq_qid    dequeued queue (PPE grant index)
//   Req        registered request vector, Req[i] = (cnt[i] != 0)
//   total_cnt  registered sum of all queue counters
//   enq_drop   one-cycle pulse: enqueue rejected, queue full
//   deq_udf    one-cycle pulse: dequeue on empty queue, ignored
//   stat_enq   accepted-enqueue count (saturating)
//   stat_drop  dropped-enqueue count (saturating)
//   stat_udf   underflow count (saturating)
module ppe_req_tracker
  import ppe_pkg::*;
#(
  parameter int N     = ppe_pkg::N,
  parameter int IDX_W = ppe_pkg::IDX_W,
  parameter int CNT_W = ppe_pkg::CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq_valid,
  input  logic [IDX_W-1:0]       enq_qid,
  input  logic                   deq_valid,
  input  logic [IDX_W-1:0]       deq_qid,
  output logic [N-1:0]           Req,
  output logic [IDX_W+CNT_W-1:0] total_cnt,
  output logic                   enq_drop,
  output logic                   deq_udf,
  output logic [31:0]            stat_enq,
  output logic [31:0]            stat_drop,
  output logic [31:0]            stat_udf
);

  logic [N-1:0] full_vec;
  logic [N-1:0] empty_vec;
  logic [N-1:0] inc_vec;
  logic [N-1:0] dec_vec;
  logic         deq_ok;
  logic         enq_ok;

  // Accept decisions from pre-edge occupancy. A dequeue accepted on the same
  // queue frees a slot, so a full queue may still take the enqueue.
  assign deq_ok = deq_valid && !empty_vec[deq_qid];
  assign enq_ok = enq_valid &&
                  (!full_vec[enq_qid] || (deq_ok && (deq_qid == enq_qid)));

  assign inc_vec = {{(N-1){1'b0}}, enq_ok} << enq_qid;
  assign dec_vec = {{(N-1){1'b0}}, deq_ok} << deq_qid;

  for (genvar i = 0; i < N; i++) begin : g_q
    ppe_req_qcnt #(.CNT_W(CNT_W)) u_qcnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_vec[i]),
      .dec   (dec_vec[i]),
      .full  (full_vec[i]),
      .empty (empty_vec[i]),
      .req   (Req[i])
    );
  end

  // Running total and single-cycle event flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      total_cnt <= '0;
      enq_drop  <= 1'b0;
      deq_udf   <= 1'b0;
    end else begin
      if (enq_ok && !deq_ok)      total_cnt <= total_cnt + 1'b1;
      else if (deq_ok && !enq_ok) total_cnt <= total_cnt - 1'b1;
      enq_drop <= enq_valid && !enq_ok;
      deq_udf  <= deq_valid && !deq_ok;
    end
  end

`ifdef PPE_REQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_enq  <= '0;
      stat_drop <= '0;
      stat_udf  <= '0;
    end else begin
      if (enq_ok && (stat_enq != '1))                stat_enq  <= stat_enq + 1'b1;
      if (enq_valid && !enq_ok && (stat_drop != '1)) stat_drop <= stat_drop + 1'b1;
      if (deq_valid && !deq_ok && (stat_udf != '1))  stat_udf  <= stat_udf + 1'b1;
    end
  end
`else
  assign stat_enq  = '0;
  assign stat_drop = '0;
  assign stat_udf  = '0;
`endif

endmodule

// File: tb/tb_ppe_req_tracker.sv
// tb_ppe_req_tracker: directed self-checking bench for ppe_req_tracker.
// Expected statistics depend on whether PPE_REQ_STATS_EN is defined.
module tb_ppe_req_tracker;

  logic         clk = 1'b0;
  logic         rst;
  logic         enq_valid;
  logic [8:0]   enq_qid;
  logic         deq_valid;
  logic [8:0]   deq_qid;
  logic [511:0] Req;
  logic [12:0]  total_cnt;
  logic         enq_drop;
  logic         deq_udf;
  logic [31:0]  stat_enq;
  logic [31:0]  stat_drop;
  logic [31:0]  stat_udf;

  int passed = 0;
  int total  = 0;

  logic [511:0] zero_req;
  logic [511:0] exp_req;

  always #5 clk = ~clk;

  ppe_req_tracker dut (
    .clk       (clk),
    .rst       (rst),
    .enq_valid (enq_valid),
    .enq_qid   (enq_qid),
    .deq_valid (deq_valid),
    .deq_qid   (deq_qid),
    .Req       (Req),
    .total_cnt (total_cnt),
    .enq_drop  (enq_drop),
    .deq_udf   (deq_udf),
    .stat_enq  (stat_enq),
    .stat_drop (stat_drop),
    .stat_udf  (stat_udf)
  );

  // Drive one cycle of inputs; returns at the following negedge, after the
  // posedge has consumed them, so outputs then reflect this event.
  task automatic cyc(input logic r, input logic e, input logic [8:0] eq,
                     input logic d, input logic [8:0] dq);
    rst       = r;
    enq_valid = e;
    enq_qid   = eq;
    deq_valid = d;
    deq_qid   = dq;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 9'd0, 1'b0, 9'd0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 9'd0, 1'b0, 9'd0);
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    total++; if (Req !== zero_req) $display("FAIL reset_req got=%h exp=0", Req); else passed++;
    total++; if (total_cnt !== 13'd0) $display("FAIL reset_total got=%0d exp=0", total_cnt); else passed++;
    total++; if ({enq_drop, deq_udf} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {enq_drop, deq_udf}); else passed++;
    total++; if ({stat_enq, stat_drop, stat_udf} !== 96'd0) $display("FAIL reset_stats got=%h exp=0", {stat_enq, stat_drop, stat_udf}); else passed++;
  endtask

  task automatic test_enq_deq_q5();
    do_reset();
    cyc(1'b0, 1'b1, 9'd5, 1'b0, 9'd0);
    total++; if (Req[5] !== 1'b1) $display("FAIL q5_req_first got=%b exp=1", Req[5]); else passed++;
    total++; if (total_cnt !== 13'd1) $display("FAIL q5_total_first got=%0d exp=1", total_cnt); else passed++;
    cyc(1'b0, 1'b1, 9'd5, 1'b0, 9'd0);
    cyc(1'b0, 1'b1, 9'd5, 1'b0, 9'd0);
    total++; if (total_cnt !== 13'd3) $display("FAIL q5_total3 got=%0d exp=3", total_cnt); else passed++;
    cyc(1'b0, 1'b0, 9'd0, 1'b1, 9'd5);
    cyc(1'b0, 1'b0, 9'd0, 1'b1, 9'd5);
    total++; if (Req[5] !== 1'b1) $display("FAIL q5_req_after2deq got=%b exp=1", Req[5]); else passed++;
    cyc(1'b0, 1'b0, 9'd0, 1'b1, 9'd5);
    total++; if (Req !== zero_req) $display("FAIL q5_req_drained got=%h exp=0", Req); else passed++;
    total++; if (total_cnt !== 13'd0) $display("FAIL q5_total0 got=%0d exp=0", total_cnt); else passed++;
    total++; if (deq_udf !== 1'b0) $display("FAIL q5_no_udf got=%b exp=0", deq_udf); else passed++;
  endtask

  task automatic test_full_drop();
    logic [31:0] exp_enq, exp_drop;
`ifdef PPE_REQ_STATS_EN
    exp_enq = 32'd15; exp_drop = 32'd1;
`else
    exp_enq = 32'd0;  exp_drop = 32'd0;
`endif
    do_reset();
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 9'd0, 1'b0, 9'd0);
    total++; if (total_cnt !== 13'd15) $display("FAIL full_total15 got=%0d exp=15", total_cnt); else passed++;
    total++; if (enq_drop !== 1'b0) $display("FAIL full_no_drop got=%b exp=0", enq_drop); else passed++;
    cyc(1'b0, 1'b1, 9'd0, 1'b0, 9'd0);
    total++; if (enq_drop !== 1'b1) $display("FAIL full_drop got=%b exp=1", enq_drop); else passed++;
    total++; if (total_cnt !== 13'd15) $display("FAIL full_total_held got=%0d exp=15", total_cnt); else passed++;
    idle();
    total++; if (enq_drop !== 1'b0) $display("FAIL full_drop_pulse got=%b exp=0", enq_drop); else passed++;
    total++; if (stat_enq !== exp_enq) $display("FAIL full_stat_enq got=%0d exp=%0d", stat_enq, exp_enq); else passed++;
    total++; if (stat_drop !== exp_drop) $display("FAIL full_stat_drop got=%0d exp=%0d", stat_drop, exp_drop); else passed++;
  endtask

  task automatic test_underflow();
    logic [31:0] exp_udf;
`ifdef PPE_REQ_STATS_EN
    exp_udf = 32'd1;
`else
    exp_udf = 32'd0;
`endif
    do_reset();
    cyc(1'b0, 1'b1, 9'd3, 1'b0, 9'd0);
    exp_req = zero_req; exp_req[3] = 1'b1;
    cyc(1'b0, 1'b0, 9'd0, 1'b1, 9'd7);
    total++; if (deq_udf !== 1'b1) $display("FAIL udf_pulse got=%b exp=1", deq_udf); else passed++;
    total++; if (Req !== exp_req) $display("FAIL udf_req got=%h exp=%h", Req, exp_req); else passed++;
    total++; if (total_cnt !== 13'd1) $display("FAIL udf_total got=%0d exp=1", total_cnt); else passed++;
    idle();
    total++; if (deq_udf !== 1'b0) $display("FAIL udf_single got=%b exp=0", deq_udf); else passed++;
    total++; if (stat_udf !== exp_udf) $display("FAIL udf_stat got=%0d exp=%0d", stat_udf, exp_udf); else passed++;
  endtask

  task automatic test_same_q9();
    do_reset();
    cyc(1'b0, 1'b1, 9'd9, 1'b1, 9'd9);
    total++; if (deq_udf !== 1'b1) $display("FAIL q9_empty_udf got=%b exp=1", deq_udf); else passed++;
    total++; if (Req[9] !== 1'b1) $display("FAIL q9_empty_req got=%b exp=1", Req[9]); else passed++;
    total++; if (total_cnt !== 13'd1) $display("FAIL q9_empty_total got=%0d exp=1", total_cnt); else passed++;
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b1, 9'd9, 1'b0, 9'd0);
    total++; if (total_cnt !== 13'd15) $display("FAIL q9_fill got=%0d exp=15", total_cnt); else passed++;
    cyc(1'b0, 1'b1, 9'd9, 1'b1, 9'd9);
    total++; if ({enq_drop, deq_udf} !== 2'b00) $display("FAIL q9_full_flags got=%b exp=00", {enq_drop, deq_udf}); else passed++;
    total++; if (total_cnt !== 13'd15) $display("FAIL q9_full_total got=%0d exp=15", total_cnt); else passed++;
    // Queue must still be at 15: a plain enqueue is now dropped.
    cyc(1'b0, 1'b1, 9'd9, 1'b0, 9'd0);
    total++; if (enq_drop !== 1'b1) $display("FAIL q9_still_full got=%b exp=1", enq_drop); else passed++;
  endtask

  task automatic test_diff_q();
    do_reset();
    cyc(1'b0, 1'b1, 9'd511, 1'b0, 9'd0);
    cyc(1'b0, 1'b1, 9'd1, 1'b1, 9'd511);
    total++; if (Req[1] !== 1'b1) $display("FAIL diff_req1 got=%b exp=1", Req[1]); else passed++;
    total++; if (Req[511] !== 1'b0) $display("FAIL diff_req511 got=%b exp=0", Req[511]); else passed++;
    total++; if (total_cnt !== 13'd1) $display("FAIL diff_total got=%0d exp=1", total_cnt); else passed++;
    total++; if ({enq_drop, deq_udf} !== 2'b00) $display("FAIL diff_flags got=%b exp=00", {enq_drop, deq_udf}); else passed++;
  endtask

  task automatic test_rst_mid();
    do_reset();
    cyc(1'b0, 1'b1, 9'd2, 1'b0, 9'd0);
    cyc(1'b0, 1'b1, 9'd2, 1'b1, 9'd7);
    total++; if (total_cnt !== 13'd2) $display("FAIL mid_pre_total got=%0d exp=2", total_cnt); else passed++;
    cyc(1'b1, 1'b1, 9'd2, 1'b1, 9'd8);
    total++; if (Req !== zero_req) $display("FAIL mid_req got=%h exp=0", Req); else passed++;
    total++; if (total_cnt !== 13'd0) $display("FAIL mid_total got=%0d exp=0", total_cnt); else passed++;
    total++; if ({enq_drop, deq_udf} !== 2'b00) $display("FAIL mid_flags got=%b exp=00", {enq_drop, deq_udf}); else passed++;
    total++; if ({stat_enq, stat_drop, stat_udf} !== 96'd0) $display("FAIL mid_stats got=%h exp=0", {stat_enq, stat_drop, stat_udf}); else passed++;
    idle();
    total++; if (total_cnt !== 13'd0) $display("FAIL mid_discard got=%0d exp=0", total_cnt); else passed++;
  endtask

  initial begin
    zero_req = '0;
    exp_req  = '0;
    test_reset();
    test_enq_deq_q5();
    test_full_drop();
    test_underflow();
    test_same_q9();
    test_diff_q();
    test_rst_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ppe_req_tracker.md
# ppe_req_tracker

Per-queue occupancy tracker that builds the 512-bit request vector for the programmable priority encoder (PPE) stage. Enqueue events increment a small counter per queue. PPE grants (index + valid) are fed back as dequeue events that decrement it. A queue asserts its request bit exactly while its counter is non-zero, so the PPE always sees a registered, glitch-free request vector.

## Interface
Parameters:
- N, 512, number of queues / request bits
- IDX_W, 9, queue index width (clog2(N))
- CNT_W, 4, per-queue occupancy counter width; max occupancy 2^CNT_W-1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enq_valid  in  1  enqueue event this cycle
- enq_qid  in  IDX_W  target queue of enqueue
- deq_valid  in  1  dequeue event; driven by PPE valid
- deq_qid  in  IDX_W  dequeued queue; driven by PPE grant index
- Req  out  N  request vector to PPE; Req[i] = (cnt[i] != 0), registered
- total_cnt  out  IDX_W+CNT_W  sum of all counters, registered
- enq_drop  out  1  one-cycle pulse: enqueue rejected (queue full)
- deq_udf  out  1  one-cycle pulse: dequeue on empty queue, ignored
- stat_enq  out  32  accepted-enqueue count (statistics)
- stat_drop  out  32  dropped-enqueue count (statistics)
- stat_udf  out  32  underflow count (statistics)

## Operation
- All decisions use pre-edge counter values; all results are registered.
- Enqueue accepted iff cnt[enq_qid] < MAX, or a deq to the same qid is accepted in the same cycle.
- Dequeue accepted iff cnt[deq_qid] != 0. Otherwise deq_udf pulses and nothing changes.
- Same qid, both valid:
  - cnt == 0: deq is underflow (deq_udf=1), enq is accepted, cnt becomes 1.
  - 0 < cnt <= MAX: both accepted, cnt unchanged, no flags.
- Different qids, both valid: independent updates in the same cycle.
- Rejected enqueue (full): enq_drop=1, cnt unchanged.
- total_cnt changes by +1, −1 or 0 per cycle to match the accepted events. It never wraps; by construction it is at most N·MAX.
- There is no FSM. The block is a per-queue counter array plus an update decoder.

## Timing
- Reset (rst sampled high at the edge) sets:
  - all cnt and Req to 0;
  - total_cnt, enq_drop, deq_udf to 0;
  - all stat_* to 0.
- rst dominates any same-cycle enq/deq; those events are lost.
- Latency: an event at edge t is visible on Req, total_cnt and the flags from t+1. Req reflects cnt after the update.
- Flags are single-cycle pulses and are never held.
- Feedback loop: PPE grant latency is 2 cycles, so a queue with cnt=1 may hold Req[i]=1 while its grant is in flight. A resulting extra deq is reported as deq_udf and ignored. It is never a counter wrap.

## Configuration
- Macro PPE_REQ_STATS_EN.
- Defined: stat_enq, stat_drop, stat_udf are 32-bit counters that saturate at 0xFFFFFFFF. Each increments once per cycle in which an accepted enq, enq_drop or deq_udf occurs, respectively.
- Undefined: no counter logic is built and stat_* are constant 0.
- Ports exist in both cases.

## Structure
- Shared package ppe_pkg holds:
  - N, IDX_W, CNT_W defaults;
  - qid_t (IDX_W-bit) and cnt_t (CNT_W-bit) typedefs;
  - localparam CNT_MAX.
- Sub-module ppe_req_qcnt: one per-queue counter cell with inc/dec strobes, full/empty outputs and a registered req bit. It is generated N times.
- The top level decodes enq_qid/deq_qid to one-hot strobes and holds total_cnt, the flags and the stats.

## Test plan
- Reset, then enq q5 ×3 on consecutive cycles → Req[5]=1 from cycle 1, total_cnt=3. Deq q5 ×3 → Req[5]=0 the cycle after the third deq, total_cnt=0.
- Enq q0 ×16 with CNT_W=4 → 15 accepted, 16th gives enq_drop=1; cnt stays 15, stat_drop=1 (macro on).
- Deq q7 while empty → deq_udf=1 for one cycle, Req unchanged, total_cnt unchanged.
- Same cycle enq+deq on q9:
  - cnt=0 → cnt=1, deq_udf=1.
  - cnt=15 → cnt=15, no enq_drop.
- Same cycle enq q1, deq q511 (cnt[511]=1) → Req[1]=1, Req[511]=0, total_cnt unchanged next cycle.
- rst asserted mid-stream with enq_valid=1 → all outputs 0 the next cycle, enqueue discarded. With the macro undefined, stat_* stay 0 throughout.
